// File: rtl/alu_pkg.sv
// Shared types for the parameterised register-file ALU: opcodes, controller
// states and status-flag bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'h0,
        OpSub = 4'h1,
        OpAnd = 4'h2,
        OpOr  = 4'h3,
        OpXor = 4'h4,
        OpShl = 4'h5,
        OpShr = 4'h6,
        OpMov = 4'h7,
        OpAdc = 4'h8,
        OpSbb = 4'h9,
        OpRol = 4'hA,
        OpRor = 4'hB,
        OpCmp = 4'hC,
        OpNot = 4'hD
    } alu_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StExec,
        StWb,
        StDone
    } alu_state_e;

    localparam int unsigned FlagZ    = 0;
    localparam int unsigned FlagC    = 1;
    localparam int unsigned FlagN    = 2;
    localparam int unsigned FlagV    = 3;
    localparam int unsigned NumFlags = 4;

    // Opcodes 0xE and 0xF are undefined.
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OpNot;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NUM_REGS x DATA_W register file: two read ports latched on rd_en, one write
// port and a combinational debug read port.
module alu_regfile #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 8,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else if (rd_en) begin
            rd_data_a <= regs_q[rd_addr_a];
            rd_data_b <= regs_q[rd_addr_b];
        end
    end

    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/param_alu_core.sv
// Multi-cycle register-file ALU: a command is latched in IDLE, then walks
// READ -> EXEC -> WB -> DONE with one state per clock.
module param_alu_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 8,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_cmd,
    input  logic [3:0]        op_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic [ADDR_W-1:0] rs1_in,
    input  logic [ADDR_W-1:0] rs2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic              imm_sel_in,
    output logic              busy,
    output logic              cmd_done,
    output logic              z_flag_out,
    output logic              c_flag_out,
    output logic              n_flag_out,
    output logic              v_flag_out,
    output logic              illegal_op_out,
    input  logic [ADDR_W-1:0] dbg_addr_in,
    output logic [DATA_W-1:0] dbg_data_out
);

    localparam int unsigned Msb = DATA_W - 1;

    alu_state_e state_q, state_d;

    logic [3:0]          op_q;
    logic [ADDR_W-1:0]   rd_q, rs1_q, rs2_q;
    logic [DATA_W-1:0]   imm_q;
    logic                imm_sel_q;

    logic [DATA_W-1:0]   opa, opb, rd_data_b;
    logic [DATA_W:0]     ea, eb, cin, sum;
    logic [DATA_W-1:0]   res, result_q;
    logic [NumFlags-1:0] flags_q, nflags, nflags_q;
    logic                legal, wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_cmd) state_d = StRead;
            StRead:  state_d = StExec;
            StExec:  state_d = StWb;
            StWb:    state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Command fields are captured only on acceptance so later input wiggles are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            imm_sel_q <= 1'b0;
        end else if (state_q == StIdle && start_cmd) begin
            op_q      <= op_in;
            rd_q      <= rd_in;
            rs1_q     <= rs1_in;
            rs2_q     <= rs2_in;
            imm_q     <= imm_in;
            imm_sel_q <= imm_sel_in;
        end
    end

    alu_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (state_q == StRead),
        .rd_addr_a (rs1_q),
        .rd_addr_b (rs2_q),
        .rd_data_a (opa),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (rd_q),
        .wr_data   (result_q),
        .dbg_addr  (dbg_addr_in),
        .dbg_data  (dbg_data_out)
    );

    assign opb   = imm_sel_q ? imm_q : rd_data_b;
    assign legal = is_legal_op(op_q);
    assign ea    = {1'b0, opa};
    assign eb    = {1'b0, opb};
    assign cin   = {{DATA_W{1'b0}}, flags_q[FlagC]};

    always_comb begin
        sum    = '0;
        res    = '0;
        nflags = flags_q;
        case (op_q)
            OpAdd, OpAdc: begin
                sum           = (op_q == OpAdc) ? ea + eb + cin : ea + eb;
                res           = sum[Msb:0];
                nflags[FlagC] = sum[DATA_W];
                nflags[FlagV] = (opa[Msb] == opb[Msb]) && (res[Msb] != opa[Msb]);
            end
            OpSub, OpSbb, OpCmp: begin
                // Top bit of the widened difference is the borrow.
                sum           = (op_q == OpSbb) ? ea - eb - cin : ea - eb;
                res           = sum[Msb:0];
                nflags[FlagC] = sum[DATA_W];
                nflags[FlagV] = (opa[Msb] != opb[Msb]) && (res[Msb] != opa[Msb]);
            end
            OpAnd: begin res = opa & opb; nflags[FlagC] = 1'b0; nflags[FlagV] = 1'b0; end
            OpOr:  begin res = opa | opb; nflags[FlagC] = 1'b0; nflags[FlagV] = 1'b0; end
            OpXor: begin res = opa ^ opb; nflags[FlagC] = 1'b0; nflags[FlagV] = 1'b0; end
            OpNot: begin res = ~opa;      nflags[FlagC] = 1'b0; nflags[FlagV] = 1'b0; end
            OpShl: begin
                res           = {opa[Msb-1:0], 1'b0};
                nflags[FlagC] = opa[Msb];
                nflags[FlagV] = 1'b0;
            end
            OpShr: begin
                res           = {1'b0, opa[Msb:1]};
                nflags[FlagC] = opa[0];
                nflags[FlagV] = 1'b0;
            end
            OpRol: begin
                res           = {opa[Msb-1:0], opa[Msb]};
                nflags[FlagC] = opa[Msb];
                nflags[FlagV] = 1'b0;
            end
            OpRor: begin
                res           = {opa[0], opa[Msb:1]};
                nflags[FlagC] = opa[0];
                nflags[FlagV] = 1'b0;
            end
            OpMov: begin res = opb; nflags[FlagV] = 1'b0; end
            default: ;
        endcase
        if (legal) begin
            nflags[FlagZ] = (res == '0);
            nflags[FlagN] = res[Msb];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            nflags_q <= '0;
        end else if (state_q == StExec) begin
            result_q <= res;
            nflags_q <= nflags;
        end
    end

    assign wr_en = (state_q == StWb) && legal && (op_q != OpCmp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (state_q == StWb && legal) begin
            flags_q <= nflags_q;
        end
    end

    assign busy           = (state_q != StIdle);
    assign cmd_done       = (state_q == StDone);
    assign illegal_op_out = (state_q == StDone) && !legal;
    assign z_flag_out     = flags_q[FlagZ];
    assign c_flag_out     = flags_q[FlagC];
    assign n_flag_out     = flags_q[FlagN];
    assign v_flag_out     = flags_q[FlagV];

endmodule

// File: tb/tb_param_alu_core.sv
// Directed bench for param_alu_core: an 8-bit/8-register instance for the main
// scenarios and a 16-bit/16-register instance for the wide shift/rotate cases.
module tb_param_alu_core;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;

    // 8-bit instance
    logic       start_cmd = 1'b0, imm_sel_in = 1'b0;
    logic [3:0] op_in = '0;
    logic [2:0] rd_in = '0, rs1_in = '0, rs2_in = '0, dbg_addr_in = '0;
    logic [7:0] imm_in = '0, dbg_data_out;
    logic       busy, cmd_done, z_flag_out, c_flag_out, n_flag_out, v_flag_out, illegal_op_out;

    param_alu_core #(.DATA_W(8), .NUM_REGS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_cmd(start_cmd), .op_in(op_in), .rd_in(rd_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in), .imm_sel_in(imm_sel_in),
        .busy(busy), .cmd_done(cmd_done), .z_flag_out(z_flag_out), .c_flag_out(c_flag_out),
        .n_flag_out(n_flag_out), .v_flag_out(v_flag_out), .illegal_op_out(illegal_op_out),
        .dbg_addr_in(dbg_addr_in), .dbg_data_out(dbg_data_out)
    );

    // 16-bit instance
    logic        h_start = 1'b0, h_imm_sel = 1'b0;
    logic [3:0]  h_op = '0;
    logic [3:0]  h_rd = '0, h_rs1 = '0, h_rs2 = '0, h_dbg_addr = '0;
    logic [15:0] h_imm = '0, h_dbg_data;
    logic        h_busy, h_done, h_z, h_c, h_n, h_v, h_ill;

    param_alu_core #(.DATA_W(16), .NUM_REGS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_cmd(h_start), .op_in(h_op), .rd_in(h_rd),
        .rs1_in(h_rs1), .rs2_in(h_rs2), .imm_in(h_imm), .imm_sel_in(h_imm_sel),
        .busy(h_busy), .cmd_done(h_done), .z_flag_out(h_z), .c_flag_out(h_c),
        .n_flag_out(h_n), .v_flag_out(h_v), .illegal_op_out(h_ill),
        .dbg_addr_in(h_dbg_addr), .dbg_data_out(h_dbg_data)
    );

    always @(negedge clk) if (cmd_done === 1'b1) done_cnt++;

    // Issues one command, scrambles the inputs after acceptance and returns the
    // number of edges from the accept edge to the first cycle with cmd_done high.
    task automatic run_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic [7:0] imm, input logic isel,
                           output int lat, output logic ill);
        @(negedge clk);
        op_in = op; rd_in = rd; rs1_in = rs1; rs2_in = rs2; imm_in = imm; imm_sel_in = isel;
        start_cmd = 1'b1;
        @(posedge clk); #1;
        start_cmd = 1'b0;
        op_in = 4'hF; rd_in = ~rd; rs1_in = ~rs1; rs2_in = ~rs2; imm_in = ~imm; imm_sel_in = ~isel;
        lat = 99; ill = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (cmd_done === 1'b1) begin lat = i; ill = illegal_op_out; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic run_cmd16(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                             input logic [15:0] imm, input logic isel, output int lat);
        @(negedge clk);
        h_op = op; h_rd = rd; h_rs1 = rs1; h_rs2 = 4'd0; h_imm = imm; h_imm_sel = isel;
        h_start = 1'b1;
        @(posedge clk); #1;
        h_start = 1'b0;
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (h_done === 1'b1) begin lat = i; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        dbg_addr_in = a; #1; d = dbg_data_out;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passes++;
        checks++; if (cmd_done !== 1'b0 || illegal_op_out !== 1'b0)
            $display("FAIL rst_pulses: got %b%b expected 00", cmd_done, illegal_op_out); else passes++;
        checks++; if ({z_flag_out, c_flag_out, n_flag_out, v_flag_out} !== 4'b0000)
            $display("FAIL rst_flags: got %b expected 0000",
                     {z_flag_out, c_flag_out, n_flag_out, v_flag_out}); else passes++;
        @(negedge clk); rst_n = 1'b1;
        peek(3'd0, d);
        checks++; if (d !== 8'h00) $display("FAIL rst_r0: got %h expected 00", d); else passes++;
        peek(3'd7, d);
        checks++; if (d !== 8'h00) $display("FAIL rst_r7: got %h expected 00", d); else passes++;
    endtask

    task automatic test_load;
        int lat; logic ill; logic [7:0] d;
        run_cmd(OpMov, 3'd1, 3'd0, 3'd0, 8'h10, 1'b1, lat, ill);
        run_cmd(OpMov, 3'd2, 3'd0, 3'd0, 8'h0A, 1'b1, lat, ill);
        run_cmd(OpMov, 3'd3, 3'd0, 3'd0, 8'hFF, 1'b1, lat, ill);
        peek(3'd1, d);
        checks++; if (d !== 8'h10) $display("FAIL mov_r1: got %h expected 10", d); else passes++;
        peek(3'd3, d);
        checks++; if (d !== 8'hFF) $display("FAIL mov_r3: got %h expected ff", d); else passes++;
        checks++; if (n_flag_out !== 1'b1) $display("FAIL mov_n: got %b expected 1", n_flag_out);
        else passes++;
    endtask

    task automatic test_add;
        int lat; logic ill; logic [7:0] d;
        run_cmd(OpAdd, 3'd4, 3'd1, 3'd2, 8'h00, 1'b0, lat, ill);
        checks++; if (lat !== 3) $display("FAIL add_latency: got %0d expected 3", lat); else passes++;
        checks++; if (ill !== 1'b0) $display("FAIL add_illegal: got %b expected 0", ill); else passes++;
        checks++; if (cmd_done !== 1'b0 || busy !== 1'b0)
            $display("FAIL add_after: got done=%b busy=%b expected 0 0", cmd_done, busy); else passes++;
        peek(3'd4, d);
        checks++; if (d !== 8'h1A) $display("FAIL add_r4: got %h expected 1a", d); else passes++;
        checks++; if ({z_flag_out, c_flag_out} !== 2'b00)
            $display("FAIL add_zc: got %b expected 00", {z_flag_out, c_flag_out}); else passes++;
    endtask

    task automatic test_carry;
        int lat; logic ill; logic [7:0] d;
        run_cmd(OpAdd, 3'd7, 3'd3, 3'd2, 8'h00, 1'b0, lat, ill);
        peek(3'd7, d);
        checks++; if (d !== 8'h09) $display("FAIL addc_r7: got %h expected 09", d); else passes++;
        checks++; if (c_flag_out !== 1'b1) $display("FAIL addc_c: got %b expected 1", c_flag_out);
        else passes++;
        run_cmd(OpAdc, 3'd6, 3'd1, 3'd2, 8'h00, 1'b0, lat, ill);
        peek(3'd6, d);
        checks++; if (d !== 8'h1B) $display("FAIL adc_r6: got %h expected 1b", d); else passes++;
        checks++; if (c_flag_out !== 1'b0) $display("FAIL adc_c: got %b expected 0", c_flag_out);
        else passes++;
    endtask

    task automatic test_sub_cmp;
        int lat; logic ill; logic [7:0] d;
        run_cmd(OpSub, 3'd5, 3'd2, 3'd1, 8'h00, 1'b0, lat, ill);
        peek(3'd5, d);
        checks++; if (d !== 8'hFA) $display("FAIL sub_r5: got %h expected fa", d); else passes++;
        checks++; if ({z_flag_out, c_flag_out, n_flag_out, v_flag_out} !== 4'b0110)
            $display("FAIL sub_flags: got %b expected 0110",
                     {z_flag_out, c_flag_out, n_flag_out, v_flag_out}); else passes++;
        run_cmd(OpCmp, 3'd0, 3'd1, 3'd0, 8'h10, 1'b1, lat, ill);
        checks++; if ({z_flag_out, c_flag_out, n_flag_out, v_flag_out} !== 4'b1000)
            $display("FAIL cmp_flags: got %b expected 1000",
                     {z_flag_out, c_flag_out, n_flag_out, v_flag_out}); else passes++;
        peek(3'd0, d);
        checks++; if (d !== 8'h00) $display("FAIL cmp_nowrite: got %h expected 00", d); else passes++;
        peek(3'd1, d);
        checks++; if (d !== 8'h10) $display("FAIL cmp_r1: got %h expected 10", d); else passes++;
        run_cmd(OpMov, 3'd0, 3'd0, 3'd0, 8'h7F, 1'b1, lat, ill);
        run_cmd(OpAdd, 3'd0, 3'd0, 3'd0, 8'h01, 1'b1, lat, ill);
        peek(3'd0, d);
        checks++; if (d !== 8'h80) $display("FAIL ovf_r0: got %h expected 80", d); else passes++;
        checks++; if ({z_flag_out, c_flag_out, n_flag_out, v_flag_out} !== 4'b0011)
            $display("FAIL ovf_flags: got %b expected 0011",
                     {z_flag_out, c_flag_out, n_flag_out, v_flag_out}); else passes++;
    endtask

    task automatic test_illegal;
        int lat; logic ill; logic [7:0] d;
        run_cmd(4'hE, 3'd2, 3'd1, 3'd1, 8'h55, 1'b0, lat, ill);
        checks++; if (lat !== 3 || ill !== 1'b1)
            $display("FAIL illegal_pulse: got lat=%0d ill=%b expected 3 1", lat, ill); else passes++;
        checks++; if (illegal_op_out !== 1'b0)
            $display("FAIL illegal_width: got %b expected 0", illegal_op_out); else passes++;
        peek(3'd2, d);
        checks++; if (d !== 8'h0A) $display("FAIL illegal_nowrite: got %h expected 0a", d);
        else passes++;
        checks++; if ({z_flag_out, c_flag_out, n_flag_out, v_flag_out} !== 4'b0011)
            $display("FAIL illegal_flags: got %b expected 0011",
                     {z_flag_out, c_flag_out, n_flag_out, v_flag_out}); else passes++;
    endtask

    // start_cmd stays high for ten edges: only the accept edges T and T+5 take effect.
    task automatic test_start_held;
        int base; logic [7:0] d;
        base = done_cnt;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start_cmd = 1'b1; imm_sel_in = 1'b1; rs1_in = 3'd1; rs2_in = 3'd2;
            case (k)
                0:       begin op_in = OpMov; rd_in = 3'd5; imm_in = 8'h33; end
                4:       begin op_in = OpMov; rd_in = 3'd6; imm_in = 8'h44; end
                5:       begin op_in = OpMov; rd_in = 3'd6; imm_in = 8'h55; end
                6:       begin op_in = OpMov; rd_in = 3'd6; imm_in = 8'h66; end
                default: begin
                    op_in = (k % 2 == 1) ? OpNot : OpXor; rd_in = 3'd7; imm_in = 8'hC3;
                end
            endcase
        end
        @(negedge clk); start_cmd = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++; if (done_cnt - base !== 2)
            $display("FAIL held_count: got %0d expected 2", done_cnt - base); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL held_busy: got %b expected 0", busy); else passes++;
        peek(3'd5, d);
        checks++; if (d !== 8'h33) $display("FAIL held_r5: got %h expected 33", d); else passes++;
        peek(3'd6, d);
        checks++; if (d !== 8'h55) $display("FAIL held_r6: got %h expected 55", d); else passes++;
        peek(3'd7, d);
        checks++; if (d !== 8'h09) $display("FAIL held_r7: got %h expected 09", d); else passes++;
    endtask

    task automatic test_reset_mid;
        int base, lat; logic ill; logic [7:0] d;
        @(negedge clk);
        op_in = OpAdd; rd_in = 3'd4; rs1_in = 3'd1; rs2_in = 3'd2; imm_sel_in = 1'b0;
        start_cmd = 1'b1;
        @(posedge clk); #1 start_cmd = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", busy);
        else passes++;
        base = done_cnt;
        @(negedge clk); rst_n = 1'b0; #1;
        checks++; if (busy !== 1'b0 || cmd_done !== 1'b0)
            $display("FAIL mid_async: got busy=%b done=%b expected 0 0", busy, cmd_done); else passes++;
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(posedge clk); #1;
        checks++; if (done_cnt !== base)
            $display("FAIL mid_nodone: got %0d expected %0d", done_cnt, base); else passes++;
        peek(3'd4, d);
        checks++; if (d !== 8'h00) $display("FAIL mid_r4: got %h expected 00", d); else passes++;
        run_cmd(OpMov, 3'd4, 3'd0, 3'd0, 8'h5A, 1'b1, lat, ill);
        peek(3'd4, d);
        checks++; if (lat !== 3 || d !== 8'h5A)
            $display("FAIL mid_restart: got lat=%0d r4=%h expected 3 5a", lat, d); else passes++;
    endtask

    task automatic test_wide;
        int lat;
        run_cmd16(OpMov, 4'd15, 4'd0, 16'h0001, 1'b1, lat);
        run_cmd16(OpRor, 4'd15, 4'd15, 16'h0000, 1'b0, lat);
        h_dbg_addr = 4'd15; #1;
        checks++; if (h_dbg_data !== 16'h8000) $display("FAIL ror_r15: got %h expected 8000", h_dbg_data);
        else passes++;
        checks++; if ({h_z, h_c, h_n, h_v} !== 4'b0110)
            $display("FAIL ror_flags: got %b expected 0110", {h_z, h_c, h_n, h_v}); else passes++;
        run_cmd16(OpShl, 4'd14, 4'd15, 16'h0000, 1'b0, lat);
        h_dbg_addr = 4'd14; #1;
        checks++; if (h_dbg_data !== 16'h0000 || lat !== 3)
            $display("FAIL shl_r14: got %h lat=%0d expected 0000 3", h_dbg_data, lat); else passes++;
        checks++; if ({h_z, h_c, h_n, h_v} !== 4'b1100)
            $display("FAIL shl_flags: got %b expected 1100", {h_z, h_c, h_n, h_v}); else passes++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_add();
        test_carry();
        test_sub_cmp();
        test_illegal();
        test_start_held();
        test_reset_mid();
        test_wide();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
